// File: rtl/shift_pla_inv.sv
// -----------------------------------------------------------------------------
// shift_pla_inv
//
// Purpose:
//   Shift-only piecewise-linear approximation of x = atanh(y), implemented as
//   a 3-stage pipeline with a valid/ready handshake on both sides. No
//   multipliers are used: every segment slope is a power of two.
//
//   Segments on a = |y| (units of 1.0):
//     a <  0.5           : m = a
//     0.5  <= a < 0.75   : m = 2a - 0.5
//     0.75 <= a < 0.875  : m = 4a - 2
//     a >= 0.875         : m = 8a - 5
//   The magnitude is truncated toward zero to the output fraction width and
//   only then negated, so the transfer function is exactly odd-symmetric.
//   y = -1 maps directly to the most negative output code.
//
// Parameters:
//   W_IN   input width,  signed Q1.(W_IN-1)           (tanh-domain value y)
//   W_OUT  output width, signed Q(OUT_I).(W_OUT-OUT_I) (argument x)
//   OUT_I  output integer bits including the sign bit
//
// Ports:
//   clock      rising-edge clock for all state
//   reset      asynchronous active-high reset, clears all valid bits and out
//   in         input sample y
//   in_valid   `in` holds a valid sample
//   in_ready   block accepts a sample this cycle
//   out        result x ~ atanh(y)
//   out_valid  `out` holds a valid result
//   out_ready  downstream accepts `out` this cycle
//
// Pipeline:
//   S1: sign, |y|, segment index, y == -1 flag
//   S2: shift and subtract segment offset
//   S3: truncate, restore sign, saturate (S3 registers drive the outputs)
// All stages advance together; the only stall source is a result waiting at
// the output that the downstream is not taking.
// -----------------------------------------------------------------------------
module shift_pla_inv #(
  parameter int W_IN  = 10,
  parameter int W_OUT = 10,
  parameter int OUT_I = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W_IN-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W_OUT-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  // Fraction bits on the input and output sides.
  localparam int FI  = W_IN - 1;
  localparam int FO  = W_OUT - OUT_I;
  // Magnitude datapath: 4 integer bits cover 8a - 5 < 3 and 8a < 8.
  localparam int MW  = FI + 4;
  // Truncated magnitude: same 4 integer bits, output fraction width.
  localparam int MTW = FO + 4;
  // Comparison width for saturation: wide enough for both the magnitude and
  // the output range limits, plus one guard bit.
  localparam int CW  = ((MTW > W_OUT) ? MTW : W_OUT) + 1;

  // Segment offsets expressed with FI fraction bits.
  localparam logic [MW-1:0] OFF_HALF = MW'(1) << (FI - 1); // 0.5
  localparam logic [MW-1:0] OFF_TWO  = MW'(2) << FI;       // 2.0
  localparam logic [MW-1:0] OFF_FIVE = MW'(5) << FI;       // 5.0

  // Output range limits, as magnitudes.
  localparam logic [CW-1:0] POS_LIM = (CW'(1) << (W_OUT - 1)) - CW'(1);
  localparam logic [CW-1:0] NEG_LIM = CW'(1) << (W_OUT - 1);

  localparam logic [W_OUT-1:0] OUT_MAX = {1'b0, {(W_OUT-1){1'b1}}};
  localparam logic [W_OUT-1:0] OUT_MIN = {1'b1, {(W_OUT-1){1'b0}}};
  localparam logic [W_IN-1:0]  IN_MIN  = {1'b1, {(W_IN-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic stall;
  logic advance;

  // Depends only on the output register and out_ready; no path from in/in_valid.
  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  // ---------------------------------------------------------------------------
  // Stage 1: sign, absolute value, segment
  // ---------------------------------------------------------------------------
  logic            v1_q;
  logic            sign1_q, sign1_d;
  logic            min1_q, min1_d;
  logic [W_IN-1:0] mag1_q, mag1_d;
  logic [1:0]      seg1_q, seg1_d;

  always_comb begin
    sign1_d = in[W_IN-1];
    min1_d  = (in == IN_MIN);
    // |y| fits in W_IN unsigned bits; -1 becomes 1.0 (MSB set), which the
    // min flag overrides at the output anyway.
    mag1_d  = sign1_d ? (~in + W_IN'(1)) : in;
    // Segment from the top three fraction bits of |y| only.
    if (!mag1_d[FI-1]) begin
      seg1_d = 2'd0;
    end else if (!mag1_d[FI-2]) begin
      seg1_d = 2'd1;
    end else if (!mag1_d[FI-3]) begin
      seg1_d = 2'd2;
    end else begin
      seg1_d = 2'd3;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      min1_q  <= 1'b0;
      mag1_q  <= '0;
      seg1_q  <= 2'd0;
    end else if (advance) begin
      v1_q    <= in_valid;
      sign1_q <= sign1_d;
      min1_q  <= min1_d;
      mag1_q  <= mag1_d;
      seg1_q  <= seg1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: shift and subtract offset
  // ---------------------------------------------------------------------------
  logic          v2_q;
  logic          sign2_q;
  logic          min2_q;
  logic [MW-1:0] m2_q, m2_d;
  logic [MW-1:0] a_ext;

  assign a_ext = MW'(mag1_q);

  // Every segment result is non-negative for its input range, so plain
  // unsigned arithmetic is exact here.
  always_comb begin
    m2_d = a_ext;
    case (seg1_q)
      2'd0:    m2_d = a_ext;
      2'd1:    m2_d = (a_ext << 1) - OFF_HALF;
      2'd2:    m2_d = (a_ext << 2) - OFF_TWO;
      default: m2_d = (a_ext << 3) - OFF_FIVE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      min2_q  <= 1'b0;
      m2_q    <= '0;
    end else if (advance) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      min2_q  <= min1_q;
      m2_q    <= m2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: truncate toward zero, restore sign, saturate
  // ---------------------------------------------------------------------------
  logic [MTW-1:0]   mt;
  logic [CW-1:0]    mt_w;
  logic [W_OUT-1:0] res_d;
  logic [W_OUT-1:0] out_q;
  logic             v3_q;

  // The magnitude is non-negative, so dropping low bits is truncation toward
  // zero. If the output has more fraction bits than the input, pad instead.
  generate
    if (FI >= FO) begin : g_trunc
      assign mt = MTW'(m2_q >> (FI - FO));
    end else begin : g_extend
      assign mt = MTW'(m2_q) << (FO - FI);
    end
  endgenerate

  always_comb begin
    mt_w  = CW'(mt);
    res_d = mt_w[W_OUT-1:0];
    if (min2_q) begin
      res_d = OUT_MIN;
    end else if (!sign2_q) begin
      if (mt_w > POS_LIM) begin
        res_d = OUT_MAX;
      end
    end else if (mt_w > NEG_LIM) begin
      res_d = OUT_MIN;
    end else begin
      // Negate only after truncation so that f(-y) == -f(y) exactly.
      res_d = W_OUT'(0) - mt_w[W_OUT-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_q  <= 1'b0;
      out_q <= '0;
    end else if (advance) begin
      v3_q  <= v2_q;
      out_q <= res_d;
    end
  end

  assign out       = out_q;
  assign out_valid = v3_q;

endmodule

// File: tb/tb_shift_pla_inv.sv
// -----------------------------------------------------------------------------
// tb_shift_pla_inv
//
// Self-checking bench for shift_pla_inv (default parameters, 10-bit in/out,
// Q1.9 in, Q4.6 out). A scoreboard queue holds expected results in
// acceptance order; expected values come either from literal constants or
// from an integer reference model of the atanh segments.
// -----------------------------------------------------------------------------
module tb_shift_pla_inv;

  logic       clock;
  logic       reset;
  logic [9:0] in_data;
  logic       in_val;
  logic       in_ready;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_rdy;

  shift_pla_inv #(.W_IN(10), .W_OUT(10), .OUT_I(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in_data),
    .in_valid  (in_val),
    .in_ready  (in_ready),
    .out       (out_data),
    .out_valid (out_valid),
    .out_ready (out_rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         n_out    = 0;
  logic       lat_chk  = 1'b0;
  logic       use_dir  = 1'b0;
  logic [9:0] dir_exp  = '0;
  logic       last_in_fire = 1'b0;
  logic       prev_stall   = 1'b0;
  logic [9:0] prev_out     = '0;
  logic       saw_ready_low = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: units of 2^-9 on the input, 2^-6 on the output.
  function automatic logic [9:0] ref_model(input logic [9:0] y);
    int yv;
    int a;
    int m;
    int r;
    yv = int'($signed(y));
    if (yv == -512) return 10'h200;
    a = (yv < 0) ? -yv : yv;
    if (a < 256)      m = a;
    else if (a < 384) m = 2 * a - 256;
    else if (a < 448) m = 4 * a - 1024;
    else              m = 8 * a - 2560;
    r = m / 8;
    if (yv < 0) r = -r;
    if (r > 511)  r = 511;
    if (r < -512) r = -512;
    return r[9:0];
  endfunction

  // One clock cycle: observe handshakes at the falling edge, then advance to
  // just after the rising edge where the driver may change inputs.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    last_in_fire = 1'b0;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_rdy)});
      if (out_valid && !in_ready) saw_ready_low = 1'b1;
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_out", {22'd0, out_data}, {22'd0, prev_out});
      end
      if (out_valid && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out", {22'd0, out_data}, {22'd0, e.data});
          if (lat_chk) check("latency", cyc - e.cyc, 32'd3);
          n_out++;
        end
      end
      if (in_val && in_ready) begin
        e.data = use_dir ? dir_exp : ref_model(in_data);
        e.cyc  = cyc;
        exp_q.push_back(e);
        last_in_fire = 1'b1;
      end
      prev_stall = out_valid && !out_rdy;
      prev_out   = out_data;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  logic [9:0] dir_in [6];
  logic [9:0] dir_out[6];
  logic [9:0] bp_in  [4];

  initial begin
    int idx;
    int guard;

    dir_in[0] = 10'b0000000000; dir_out[0] = 10'b0000000000;
    dir_in[1] = 10'b0010000000; dir_out[1] = 10'b0000010000;
    dir_in[2] = 10'b0101000000; dir_out[2] = 10'b0000110000;
    dir_in[3] = 10'b0111100000; dir_out[3] = 10'b0010100000;
    dir_in[4] = 10'b1001100000; dir_out[4] = 10'b1110110000;
    dir_in[5] = 10'b1000000000; dir_out[5] = 10'b1000000000;
    bp_in[0] = 10'h07F; bp_in[1] = 10'h1C3; bp_in[2] = 10'h2A5; bp_in[3] = 10'h3F0;

    reset = 1'b1; in_val = 1'b0; in_data = '0; out_rdy = 1'b1;
    #1;
    // Reset state, before any clock edge and after a few.
    check("rst_out_valid_async", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready_async", {31'd0, in_ready}, 32'd1);
    repeat (3) cycle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out", {22'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    cycle();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed segment sweep and negative inputs, one per cycle.
    lat_chk = 1'b1;
    use_dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_val = 1'b1; in_data = dir_in[i]; dir_exp = dir_out[i];
      cycle();
    end
    in_val = 1'b0;
    repeat (5) cycle();
    check("dir_drained", exp_q.size(), 32'd0);
    use_dir = 1'b0;

    // Backpressure: 4 samples back-to-back, out_ready low for 5 cycles.
    lat_chk = 1'b0;
    saw_ready_low = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      out_rdy = !(c >= 3 && c < 8);
      if (idx < 4) begin
        in_val = 1'b1; in_data = bp_in[idx];
      end else begin
        in_val = 1'b0;
      end
      cycle();
      if (last_in_fire) idx++;
    end
    out_rdy = 1'b1;
    check("bp_ready_dropped", {31'd0, saw_ready_low}, 32'd1);
    check("bp_all_sent", idx, 32'd4);
    check("bp_drained", exp_q.size(), 32'd0);

    // Reset mid-flight: two accepted samples must never appear.
    lat_chk = 1'b1;
    in_val = 1'b1; in_data = 10'h0C0; cycle();
    in_val = 1'b1; in_data = 10'h3A0; cycle();
    in_val = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out", {22'd0, out_data}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    cycle();
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("midrst_no_out", {31'd0, out_valid}, 32'd0);
    end
    in_val = 1'b1; in_data = 10'h150; cycle();
    in_val = 1'b0;
    repeat (4) cycle();
    check("fresh_drained", exp_q.size(), 32'd0);
    lat_chk = 1'b0;

    // Exhaustive sweep with random valid/ready.
    n_out = 0;
    idx = 0;
    guard = 0;
    while (idx < 1024 && guard < 20000) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_data = 10'(idx);
      out_rdy = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_in_fire) idx++;
      guard++;
    end
    check("sweep_all_accepted", idx, 32'd1024);
    in_val = 1'b0;
    out_rdy = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      cycle();
      guard++;
    end
    repeat (3) cycle();
    check("sweep_drained", exp_q.size(), 32'd0);
    check("sweep_out_count", n_out, 32'd1024);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_pla_inv.md
SHIFT_PLA_INV -- requirements
Module: shift_pla_inv

Interface
REQ-001 Parameter W_IN, default 10: input wordlength, signed two's complement Q1.(W_IN-1), the tanh-domain value y.
REQ-002 Parameter W_OUT, default 10: output wordlength, signed two's complement Q(OUT_I).(W_OUT-OUT_I), the argument x.
REQ-003 Parameter OUT_I, default 4: number of output integer bits, sign bit included.
REQ-004 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port in, input, W_IN: sample y.
REQ-007 Port in_valid, input, 1: `in` holds a valid sample.
REQ-008 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-009 Port out, output, W_OUT: result x, approximately atanh(y).
REQ-010 Port out_valid, output, 1: `out` holds a valid result.
REQ-011 Port out_ready, input, 1: downstream accepts `out` this cycle.

Function
REQ-012 The block SHALL compute a shift-only piecewise-linear atanh of a = |y|, using no multipliers:
- a < 0.5: m = a
- 0.5 <= a < 0.75: m = 2a - 0.5
- 0.75 <= a < 0.875: m = 4a - 2
- a >= 0.875: m = 8a - 5
REQ-013 Segment selection SHALL use only the top three fraction bits of a.
REQ-014 Magnitude arithmetic SHALL keep W_IN-1 fraction bits and at least 4 integer bits, so no overflow occurs.
REQ-015 The magnitude m SHALL be truncated toward zero to W_OUT-OUT_I fraction bits, and only then negated when y < 0, so the result is exactly odd-symmetric.
REQ-016 If the signed result exceeds the output range, it SHALL saturate to the most positive or most negative W_OUT code.
REQ-017 Input y = -1 (only MSB set) SHALL produce the most negative output code.
REQ-018 The datapath SHALL be a 3-stage registered pipeline:
- S1: sign, |y|, segment
- S2: shift and subtract offset
- S3: truncate, sign restore, saturate
REQ-019 Each stage SHALL carry its own valid bit.
REQ-020 Latency SHALL be exactly 3 clock cycles from an accepted input to out_valid when no stall occurs.
REQ-021 A transfer SHALL occur on a rising edge where valid and ready are both high; the input and output sides are independent.
REQ-022 in_ready SHALL equal NOT(out_valid AND NOT out_ready); while this is low, all stages SHALL hold.
REQ-023 Bubbles SHALL propagate as cleared valid bits, and results SHALL leave in acceptance order with no loss or duplication.
REQ-024 While out_valid is high and out_ready is low, `out` SHALL remain stable.
REQ-025 Sustained throughput SHALL be one sample per cycle when out_ready is held high.
REQ-026 in_ready SHALL depend only on registered state and out_ready, with no combinational path from in_valid or `in`.

Reset
REQ-027 While reset is high, all stage valid bits, out_valid, and `out` SHALL be 0, regardless of the clock.
REQ-028 in_ready SHALL be 1 during and after reset.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight samples.
REQ-030 The first sample accepted after reset deassertion SHALL appear 3 cycles later.

Verification
REQ-031 Segment sweep, one sample per cycle, out_ready=1; each result appears 3 cycles after its input:
- in 10'b0000000000 -> out 10'b0000_000000
- in 10'b0010000000 (0.25) -> out 10'b0000_010000 (0.25)
- in 10'b0101000000 (0.625) -> out 10'b0000_110000 (0.75)
- in 10'b0111100000 (0.9375) -> out 10'b0010_100000 (2.5)
REQ-032 Negative inputs and symmetry:
- in 10'b1001100000 (-0.8125) -> out 10'b1110_110000 (-1.25)
- in 10'b1000000000 (-1) -> out 10'b1000_000000
REQ-033 Backpressure: send 4 samples back-to-back, then hold out_ready=0 for 5 cycles -> in_ready drops once out_valid is high; the 4 results emerge in order with `out` stable throughout the stall.
REQ-034 Reset mid-flight: accept 2 samples, assert reset one cycle later for 1 cycle -> out_valid never rises for either sample; a fresh sample accepted afterward appears at latency 3.
REQ-035 Exhaustive sweep of all 1024 inputs with random in_valid/out_ready -> outputs match a reference model of REQ-012 to REQ-017 bit-exactly, in order, each value once.
